skew_feeder_bank: RTL and testbench
===================================

# skew_feeder_bank

Multi-channel input skewing buffer for the systolic matrix multiplier. It accepts one CHANNELS-wide vector per handshake. Each channel gets its own delay: channel c is delayed by BASE_DEPTH + c shift steps, so row/column operands enter the PE array in the diagonal wavefront the array expects. Each data stage carries a valid bit. The block tracks tile boundaries and automatically drains with zeros after the last vector of a tile.

## Interface
- DATA_WIDTH, 8, bits per channel element
- CHANNELS, 4, number of skewed channels (≥1)
- BASE_DEPTH, 1, delay of channel 0 in shift steps (≥1); MAXD = BASE_DEPTH + CHANNELS − 1
- clk  in  1  single clock; everything on posedge
- reset_n  in  1  synchronous, active-low reset
- sync_clear  in  1  synchronous clear; same effect as reset
- in_valid  in  1  input vector valid
- in_ready  out  1  block accepts a vector
- in_last  in  1  qualifies the accepted vector as the last of a tile
- data_i  in  CHANNELS×DATA_WIDTH  element c at bits [c*DATA_WIDTH +: DATA_WIDTH]
- out_ready  in  1  downstream can take a step (only with SKEW_BACKPRESSURE_EN)
- data_o  out  CHANNELS×DATA_WIDTH  last stage of each channel
- valid_o  out  CHANNELS  valid bit of each channel's last stage
- tile_done  out  1  one-cycle pulse after a tile has fully drained

## Operation
- Each channel c is a chain of D_c = BASE_DEPTH + c stages, each stage holding {valid, data}.
- On a shift, stage 0 loads the input and every other stage loads its predecessor. With no shift, all stages hold.
- step_ok = out_ready when the macro is defined, else 1.
- accept = in_valid & in_ready.
- shift = step_ok & (accept | state==DRAIN).
- FSM states: IDLE, STREAM, DRAIN.
  - IDLE → STREAM: on accept with !in_last.
  - IDLE or STREAM → DRAIN: on accept with in_last.
  - STREAM holds when there is no accept. Data is frozen; there is no timeout.
  - DRAIN: each shift injects data 0 with valid 0 and increments drain_cnt. The shift where drain_cnt == MAXD−1 moves the FSM to IDLE, clears drain_cnt and sets tile_done for the next cycle.
- in_ready = reset_n & step_ok & (state != DRAIN). It is combinational.
- Priority: reset_n low > sync_clear > shift.
  - Clear/reset sets all stages to 0, all valid bits to 0, state to IDLE, drain_cnt to 0 and tile_done to 0.
  - A clear mid-tile or mid-drain discards the tile and produces no tile_done.
- Elements pass through unmodified; there is no arithmetic on data.
- drain_cnt width is $clog2(MAXD+1).

## Timing
- Reset values: data_o = 0, valid_o = 0, tile_done = 0, in_ready = 0 while reset_n is low, then 1 once the block is in IDLE.
- Latency: an element accepted at edge t appears on channel c at cycle t + D_c, provided a shift occurs every cycle.
- Drain takes exactly MAXD shift cycles. The final shift clears the last valid bit, and tile_done is high in the following cycle.
- Back-to-back tiles: a new vector is accepted in the same cycle tile_done is high.

## Configuration
- SKEW_BACKPRESSURE_EN defined:
  - The out_ready port exists.
  - No shift occurs while out_ready = 0, in STREAM or DRAIN.
  - in_ready is deasserted while out_ready = 0.
  - data_o and valid_o hold stable.
- SKEW_BACKPRESSURE_EN undefined:
  - out_ready is absent and step_ok = 1.
  - The downstream must accept data_o every cycle.

## Structure
- Shared package skew_pkg holds:
  - typedef enum logic [1:0] {IDLE, STREAM, DRAIN} skew_state_t
  - function skew_max_depth(BASE_DEPTH, CHANNELS)
- Sub-module valid_delay_line, parametrised by DATA_WIDTH and DEPTH:
  - ports clk, reset_n, sync_clear, shift, valid_i, data_i, valid_o, data_o
  - instantiated CHANNELS times in a generate loop with DEPTH = BASE_DEPTH + c.

## Test plan
- CHANNELS=4, BASE_DEPTH=1. Accept one vector {0x44,0x33,0x22,0x11} with in_last at edge t:
  - ch0 shows 0x11 at t+1, ch1 shows 0x22 at t+2, ch2 shows 0x33 at t+3, ch3 shows 0x44 at t+4.
  - in_ready is 0 during t+1..t+4.
  - tile_done is high at t+5 only.
- Stream 3 vectors back-to-back, the last with in_last:
  - valid_o = 0001, 0011, 0111, 1110, 1100, 1000, 0000 on consecutive cycles.
  - Exactly one tile_done pulse.
- Gap in STREAM: accept vector A, hold in_valid = 0 for 5 cycles.
  - data_o and valid_o stay frozen.
  - Next accept resumes the skew correctly.
- Assert sync_clear at the second drain cycle:
  - All valid_o = 0 and data_o = 0 next cycle.
  - No tile_done; in_ready = 1.
- With SKEW_BACKPRESSURE_EN, drop out_ready for 3 cycles mid-drain:
  - Outputs hold; drain takes 3 extra cycles.
  - tile_done is delayed by exactly 3.
- Accept a new vector in the tile_done cycle:
  - It appears on ch0 one cycle later with valid_o[0] = 1.

Source files
------------

// File: rtl/skew_pkg.sv
// Shared types and helpers for the skew feeder bank: FSM state encoding and
// the deepest channel delay used to size the drain.
package skew_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } skew_state_t;

    // Channel c is delayed by base_depth + c, so the last channel sets the drain length.
    function automatic int skew_max_depth(input int base_depth, input int channels);
        return base_depth + channels - 1;
    endfunction

endpackage

// File: rtl/skew_feeder_bank_if.sv
// Vector handshake and skewed output bus of the skew feeder bank.
// out_ready exists only when SKEW_BACKPRESSURE_EN is defined.
interface skew_feeder_bank_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 4
);
    logic                           in_valid;
    logic                           in_ready;
    logic                           in_last;
    logic [CHANNELS*DATA_WIDTH-1:0] data_i;
    logic [CHANNELS*DATA_WIDTH-1:0] data_o;
    logic [CHANNELS-1:0]            valid_o;
    logic                           tile_done;
`ifdef SKEW_BACKPRESSURE_EN
    logic                           out_ready;

    modport master (
        output in_valid, in_last, data_i, out_ready,
        input  in_ready, data_o, valid_o, tile_done
    );
    modport slave (
        input  in_valid, in_last, data_i, out_ready,
        output in_ready, data_o, valid_o, tile_done
    );
`else
    modport master (
        output in_valid, in_last, data_i,
        input  in_ready, data_o, valid_o, tile_done
    );
    modport slave (
        input  in_valid, in_last, data_i,
        output in_ready, data_o, valid_o, tile_done
    );
`endif
endinterface

// File: rtl/valid_delay_line.sv
// Fixed-depth shift chain of {valid, data} stages for one skewed channel.
// All stages advance together on shift and hold otherwise.
module valid_delay_line #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sync_clear,
    input  logic                  shift,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DEPTH-1:0]                 r_valid;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] r_data;

    // NOTE: the data stages are cleared along with the valid bits because zero
    // data on the output is part of the observable reset/clear state.
    // NOTE: non-blocking assignments let every stage read its predecessor's
    // old value in the same edge, which is what makes this a shift register.
    always_ff @(posedge clk) begin
        if (!reset_n || sync_clear) begin
            r_valid <= '0;
            r_data  <= '0;
        end else if (shift) begin
            r_valid[0] <= valid_i;
            r_data[0]  <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_data[i]  <= r_data[i-1];
            end
        end
    end

    assign valid_o = r_valid[DEPTH-1];
    assign data_o  = r_data[DEPTH-1];

endmodule

// File: rtl/skew_feeder_bank.sv
// Skewing input buffer for the systolic array: channel c is delayed by
// BASE_DEPTH + c steps, and each tile is flushed with zeros after its last vector.
// Optional feature macro: SKEW_BACKPRESSURE_EN (adds out_ready stall control).
module skew_feeder_bank
    import skew_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 4,
    parameter int BASE_DEPTH = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sync_clear,
    skew_feeder_bank_if.slave  bus
);

    localparam int MAXD  = skew_max_depth(BASE_DEPTH, CHANNELS);
    localparam int CNT_W = $clog2(MAXD + 1);

    skew_state_t                    r_state;
    skew_state_t                    w_state_nxt;
    logic [CNT_W-1:0]               r_drain_cnt;
    logic [CNT_W-1:0]               w_drain_cnt_nxt;
    logic                           r_tile_done;
    logic                           w_tile_done_nxt;

    logic                           w_step_ok;
    logic                           w_in_ready;
    logic                           w_accept;
    logic                           w_shift;
    logic [CHANNELS*DATA_WIDTH-1:0] w_inject_data;

`ifdef SKEW_BACKPRESSURE_EN
    assign w_step_ok = bus.out_ready;
`else
    assign w_step_ok = 1'b1;
`endif

    assign w_in_ready    = reset_n & w_step_ok & (r_state != DRAIN);
    assign w_accept      = bus.in_valid & w_in_ready;
    assign w_shift       = w_step_ok & (w_accept | (r_state == DRAIN));
    // Outside an accept the only shifts are drain steps, which inject zeros.
    assign w_inject_data = w_accept ? bus.data_i : '0;

    assign bus.in_ready  = w_in_ready;
    assign bus.tile_done = r_tile_done;

    always_ff @(posedge clk) begin
        if (!reset_n || sync_clear) begin
            r_state     <= IDLE;
            r_drain_cnt <= '0;
            r_tile_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_tile_done <= w_tile_done_nxt;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        w_tile_done_nxt = 1'b0;
        case (r_state)
            IDLE, STREAM: begin
                if (w_accept) begin
                    w_state_nxt = bus.in_last ? DRAIN : STREAM;
                end
            end
            DRAIN: begin
                if (w_shift) begin
                    if (r_drain_cnt == CNT_W'(MAXD - 1)) begin
                        w_state_nxt     = IDLE;
                        w_drain_cnt_nxt = '0;
                        w_tile_done_nxt = 1'b1;
                    end else begin
                        w_drain_cnt_nxt = r_drain_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        valid_delay_line #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (BASE_DEPTH + c)
        ) u_line (
            .clk        (clk),
            .reset_n    (reset_n),
            .sync_clear (sync_clear),
            .shift      (w_shift),
            .valid_i    (w_accept),
            .data_i     (w_inject_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .valid_o    (bus.valid_o[c]),
            .data_o     (bus.data_o[c*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_skew_feeder_bank.sv
// Self-checking bench for skew_feeder_bank: directed scenarios plus random traffic
// against a shift-history reference model.
module tb_skew_feeder_bank;

    localparam int DW   = 8;
    localparam int CH   = 4;
    localparam int BASE = 1;
    localparam int MAXD = BASE + CH - 1;

    typedef struct packed {
        logic          v;
        logic [CH*DW-1:0] d;
    } inj_t;

    logic clk;
    logic reset_n;
    logic sync_clear;

    skew_feeder_bank_if #(.DATA_WIDTH(DW), .CHANNELS(CH)) bus ();

    skew_feeder_bank #(
        .DATA_WIDTH (DW),
        .CHANNELS   (CH),
        .BASE_DEPTH (BASE)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sync_clear (sync_clear),
        .bus        (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   checks   = 0;
    int   failures = 0;

    // Reference model: history of what each shift injected (newest first).
    // Channel c shows the entry injected BASE+c shifts ago.
    inj_t hist[$];
    int   m_drain_left = 0;
    logic m_done       = 1'b0;
    logic m_step_ok    = 1'b1;

    function automatic void model_out(output logic [CH-1:0] ev, output logic [CH*DW-1:0] ed);
        ev = '0;
        ed = '0;
        for (int c = 0; c < CH; c++) begin
            int dd;
            dd = BASE + c;
            if (hist.size() >= dd) begin
                ev[c]            = hist[dd-1].v;
                ed[c*DW +: DW]   = hist[dd-1].d[c*DW +: DW];
            end
        end
    endfunction

    function automatic logic model_ready();
        return reset_n && (m_drain_left == 0) && m_step_ok;
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, return at negedge.
    task automatic tick(input logic v, input logic last, input logic [CH*DW-1:0] d,
                        input logic ordy, input logic clr);
        logic step_ok, accept, shift;
        bus.in_valid = v;
        bus.in_last  = last;
        bus.data_i   = d;
        sync_clear   = clr;
`ifdef SKEW_BACKPRESSURE_EN
        bus.out_ready = ordy;
        step_ok       = ordy;
`else
        step_ok       = 1'b1;
`endif
        accept = v && reset_n && step_ok && (m_drain_left == 0);
        shift  = step_ok && (accept || (m_drain_left > 0));
        @(posedge clk);
        m_done = 1'b0;
        if (!reset_n || clr) begin
            hist.delete();
            m_drain_left = 0;
        end else if (shift) begin
            if (m_drain_left > 0) begin
                hist.push_front('{v: 1'b0, d: '0});
                m_drain_left--;
                if (m_drain_left == 0) m_done = 1'b1;
            end else begin
                hist.push_front('{v: 1'b1, d: d});
                if (last) m_drain_left = MAXD;
            end
            while (hist.size() > MAXD) void'(hist.pop_back());
        end
        m_step_ok = step_ok;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [CH-1:0]    ev;
        logic [CH*DW-1:0] ed;
        reset_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b0, CH*DW'($urandom), 1'b1, 1'b0);
            checks++;
            if (bus.valid_o !== '0) begin failures++; $display("FAIL reset valid_o got=%b exp=0", bus.valid_o); end
            checks++;
            if (bus.data_o !== '0) begin failures++; $display("FAIL reset data_o got=%h exp=0", bus.data_o); end
            checks++;
            if (bus.tile_done !== 1'b0) begin failures++; $display("FAIL reset tile_done got=%b exp=0", bus.tile_done); end
            checks++;
            if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset in_ready got=%b exp=0", bus.in_ready); end
        end
        bus.in_valid = 1'b0;
        reset_n      = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_release in_ready got=%b exp=1", bus.in_ready); end
        tick(1'b0, 1'b0, '0, 1'b1, 1'b0);
        model_out(ev, ed);
        checks++;
        if (bus.valid_o !== ev) begin failures++; $display("FAIL post_reset valid_o got=%b exp=%b", bus.valid_o, ev); end
    endtask

    task automatic test_single_vector();
        logic [CH-1:0]    ev;
        logic [CH*DW-1:0] ed;
        for (int k = 0; k < 6; k++) begin
            if (k == 0) tick(1'b1, 1'b1, 32'h44332211, 1'b1, 1'b0);
            else        tick(1'b0, 1'b0, '0, 1'b1, 1'b0);
            ev = (k < 4) ? CH'(1 << k) : '0;
            ed = (k < 4) ? (CH*DW)'((8'h11 * (k + 1)) << (8 * k)) : '0;
            checks++;
            if (bus.valid_o !== ev) begin failures++; $display("FAIL single valid_o k=%0d got=%b exp=%b", k, bus.valid_o, ev); end
            checks++;
            if (bus.data_o !== ed) begin failures++; $display("FAIL single data_o k=%0d got=%h exp=%h", k, bus.data_o, ed); end
            checks++;
            if (bus.in_ready !== (k >= 4)) begin failures++; $display("FAIL single in_ready k=%0d got=%b exp=%b", k, bus.in_ready, k >= 4); end
            checks++;
            if (bus.tile_done !== (k == 4)) begin failures++; $display("FAIL single tile_done k=%0d got=%b exp=%b", k, bus.tile_done, k == 4); end
        end
    endtask

    task automatic test_back_to_back();
        logic [CH-1:0]    ev;
        logic [CH*DW-1:0] ed;
        logic [CH-1:0]    vtab [9];
        int               pulses;
        vtab   = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        pulses = 0;
        for (int k = 0; k < 9; k++) begin
            if (k < 3) tick(1'b1, k == 2, CH*DW'($urandom), 1'b1, 1'b0);
            else       tick(1'b0, 1'b0, '0, 1'b1, 1'b0);
            model_out(ev, ed);
            if (bus.tile_done === 1'b1) pulses++;
            checks++;
            if (bus.valid_o !== vtab[k]) begin failures++; $display("FAIL b2b valid_o k=%0d got=%b exp=%b", k, bus.valid_o, vtab[k]); end
            checks++;
            if (bus.data_o !== ed) begin failures++; $display("FAIL b2b data_o k=%0d got=%h exp=%h", k, bus.data_o, ed); end
            checks++;
            if (bus.tile_done !== (k == 6)) begin failures++; $display("FAIL b2b tile_done k=%0d got=%b exp=%b", k, bus.tile_done, k == 6); end
        end
        checks++;
        if (pulses != 1) begin failures++; $display("FAIL b2b pulse_count got=%0d exp=1", pulses); end
    endtask

    task automatic test_gap();
        logic [CH-1:0]    ev;
        logic [CH*DW-1:0] ed;
        logic [CH*DW-1:0] a;
        a = CH*DW'($urandom);
        for (int k = 0; k < 12; k++) begin
            if (k == 0)      tick(1'b1, 1'b0, a, 1'b1, 1'b0);
            else if (k == 6) tick(1'b1, 1'b1, CH*DW'($urandom), 1'b1, 1'b0);
            else             tick(1'b0, 1'b0, '0, 1'b1, 1'b0);
            model_out(ev, ed);
            if (k < 6) begin
                checks++;
                if (bus.valid_o !== 4'b0001 || bus.data_o[DW-1:0] !== a[DW-1:0]) begin
                    failures++;
                    $display("FAIL gap frozen k=%0d got=%b/%h exp=0001/%h", k, bus.valid_o, bus.data_o[DW-1:0], a[DW-1:0]);
                end
            end
            checks++;
            if (bus.valid_o !== ev) begin failures++; $display("FAIL gap valid_o k=%0d got=%b exp=%b", k, bus.valid_o, ev); end
            checks++;
            if (bus.data_o !== ed) begin failures++; $display("FAIL gap data_o k=%0d got=%h exp=%h", k, bus.data_o, ed); end
            checks++;
            if (bus.in_ready !== model_ready()) begin failures++; $display("FAIL gap in_ready k=%0d got=%b exp=%b", k, bus.in_ready, model_ready()); end
            checks++;
            if (bus.tile_done !== m_done) begin failures++; $display("FAIL gap tile_done k=%0d got=%b exp=%b", k, bus.tile_done, m_done); end
        end
    endtask

    task automatic test_clear_mid_drain();
        tick(1'b1, 1'b1, CH*DW'($urandom), 1'b1, 1'b0);
        tick(1'b0, 1'b0, '0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, '0, 1'b1, 1'b1);
        sync_clear = 1'b0;
        checks++;
        if (bus.valid_o !== '0 || bus.data_o !== '0) begin
            failures++;
            $display("FAIL clear outputs got=%b/%h exp=0/0", bus.valid_o, bus.data_o);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL clear in_ready got=%b exp=1", bus.in_ready); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (bus.tile_done !== 1'b0) begin failures++; $display("FAIL clear tile_done k=%0d got=%b exp=0", k, bus.tile_done); end
            tick(1'b0, 1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_accept_on_done();
        logic [CH*DW-1:0] b;
        b = CH*DW'($urandom);
        tick(1'b1, 1'b1, CH*DW'($urandom), 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (bus.tile_done !== 1'b1) begin failures++; $display("FAIL done_accept tile_done got=%b exp=1", bus.tile_done); end
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL done_accept in_ready got=%b exp=1", bus.in_ready); end
        tick(1'b1, 1'b1, b, 1'b1, 1'b0);
        checks++;
        if (bus.valid_o[0] !== 1'b1 || bus.data_o[DW-1:0] !== b[DW-1:0]) begin
            failures++;
            $display("FAIL done_accept ch0 got=%b/%h exp=1/%h", bus.valid_o[0], bus.data_o[DW-1:0], b[DW-1:0]);
        end
        for (int k = 0; k < MAXD + 1; k++) tick(1'b0, 1'b0, '0, 1'b1, 1'b0);
    endtask

`ifdef SKEW_BACKPRESSURE_EN
    task automatic test_backpressure();
        logic [CH-1:0]    ev;
        logic [CH*DW-1:0] ed;
        for (int k = 0; k < 10; k++) begin
            if (k == 0)                tick(1'b1, 1'b1, CH*DW'($urandom), 1'b1, 1'b0);
            else if (k >= 2 && k <= 4) tick(1'b1, 1'b0, CH*DW'($urandom), 1'b0, 1'b0);
            else                       tick(1'b0, 1'b0, '0, 1'b1, 1'b0);
            model_out(ev, ed);
            if (k >= 1 && k <= 4) begin
                checks++;
                if (bus.valid_o !== 4'b0010) begin failures++; $display("FAIL bp hold valid_o k=%0d got=%b exp=0010", k, bus.valid_o); end
            end
            checks++;
            if (bus.data_o !== ed) begin failures++; $display("FAIL bp data_o k=%0d got=%h exp=%h", k, bus.data_o, ed); end
            checks++;
            if (bus.in_ready !== model_ready()) begin failures++; $display("FAIL bp in_ready k=%0d got=%b exp=%b", k, bus.in_ready, model_ready()); end
            checks++;
            if (bus.tile_done !== (k == 7)) begin failures++; $display("FAIL bp tile_done k=%0d got=%b exp=%b", k, bus.tile_done, k == 7); end
        end
    endtask
`endif

    task automatic test_random();
        logic [CH-1:0]    ev;
        logic [CH*DW-1:0] ed;
        for (int k = 0; k < 400; k++) begin
            tick(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), CH*DW'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
            model_out(ev, ed);
            checks++;
            if (bus.valid_o !== ev) begin failures++; $display("FAIL rand valid_o k=%0d got=%b exp=%b", k, bus.valid_o, ev); end
            checks++;
            if (bus.data_o !== ed) begin failures++; $display("FAIL rand data_o k=%0d got=%h exp=%h", k, bus.data_o, ed); end
            checks++;
            if (bus.in_ready !== model_ready()) begin failures++; $display("FAIL rand in_ready k=%0d got=%b exp=%b", k, bus.in_ready, model_ready()); end
            checks++;
            if (bus.tile_done !== m_done) begin failures++; $display("FAIL rand tile_done k=%0d got=%b exp=%b", k, bus.tile_done, m_done); end
        end
        tick(1'b0, 1'b0, '0, 1'b1, 1'b1);
    endtask

    initial begin
        reset_n      = 1'b0;
        sync_clear   = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.data_i   = '0;
`ifdef SKEW_BACKPRESSURE_EN
        bus.out_ready = 1'b1;
`endif
        test_reset();
        test_single_vector();
        test_back_to_back();
        test_gap();
        test_clear_mid_drain();
        test_accept_on_done();
`ifdef SKEW_BACKPRESSURE_EN
        test_backpressure();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
